ifetch_stage: RTL

// - Instruction-fetch front end of the cpu: owns the PC, drives the synchronous instruction SRAM (imem), and hands
//   {instr, pc, pc+4} to the decode stage over a valid/ready handshake.
// - Absorbs the 1-cycle imem read latency and decode back-pressure without dropping or duplicating instructions.
// - Accepts branch/jump redirects from execute, squashing wrong-path fetches.

---
 rtl/ifetch_stage_pkg.sv | 29 ++
 rtl/ifetch_stage_if.sv | 30 +++
 rtl/ifetch_stage_fetch_skid_buf.sv | 59 +++++
 rtl/ifetch_stage.sv | 72 +++++++
 4 files changed

// File: rtl/ifetch_stage_pkg.sv
// rtl/ifetch_stage_pkg.sv - shared widths, fetch bundle type and bundle builder
// Purpose: common definitions for the fetch stage, its interface and its skid buffer.
// Contents: ADDR_W/DATA_W widths, default reset PC and increment, fetch_bundle_t, make_bundle().
package ifetch_stage_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [ADDR_W-1:0] DEFAULT_PC_INC   = 32'd4;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
  } fetch_bundle_t;

  // pc_plus4 wraps silently at 2^ADDR_W
  function automatic fetch_bundle_t make_bundle(input logic [DATA_W-1:0] instr,
                                                input logic [ADDR_W-1:0] pc,
                                                input logic [ADDR_W-1:0] inc);
    fetch_bundle_t b;
    b.instr    = instr;
    b.pc       = pc;
    b.pc_plus4 = pc + inc;
    return b;
  endfunction

endpackage

// File: rtl/ifetch_stage_if.sv
// rtl/ifetch_stage_if.sv - imem, redirect and decode handshake bundle of the fetch stage
// Purpose: groups every non-clock/reset signal of ifetch_stage.
// master: fetch side (drives imem_en/imem_addr and the if_* bundle; takes imem_rdata, redirect_*, if_ready)
// slave : environment side (imem, execute and decode)
interface ifetch_stage_if
  import ifetch_stage_pkg::*;
  ();

  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic [ADDR_W-1:0] if_pc_plus4;

  modport master (
    output imem_en, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    input  imem_rdata, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_en, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    output imem_rdata, redirect_valid, redirect_pc, if_ready
  );

endinterface

// File: rtl/ifetch_stage_fetch_skid_buf.sv
// rtl/ifetch_stage_fetch_skid_buf.sv - output register plus one-entry hold buffer
// Purpose: presents fetch bundles to decode, absorbing one extra bundle under back-pressure.
// Ports: clk, reset (async, active-high), flush (drop everything held),
//        in_valid/in_data (imem response), out_valid/out_data/out_ready (decode side),
//        hold_valid (hold entry occupied, used by the issue logic).
module fetch_skid_buf
  import ifetch_stage_pkg::*;
  (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  input  fetch_bundle_t in_data,
  output logic          out_valid,
  output fetch_bundle_t out_data,
  input  logic          out_ready,
  output logic          hold_valid
);

  logic          out_valid_q;
  fetch_bundle_t out_q;
  logic          hold_valid_q;
  fetch_bundle_t hold_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      hold_valid_q <= 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // Output slot frees up: oldest entry (hold) first, then the response.
      if (hold_valid_q) begin
        out_q        <= hold_q;
        out_valid_q  <= 1'b1;
        hold_valid_q <= in_valid;
        if (in_valid) hold_q <= in_data;
      end else if (in_valid) begin
        out_q       <= in_data;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_valid) begin
      // Stalled with a response arriving: park it. The issue logic never
      // allows a response when the hold entry is already occupied.
      hold_q       <= in_data;
      hold_valid_q <= 1'b1;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_q;
  assign hold_valid = hold_valid_q;

endmodule

// File: rtl/ifetch_stage.sv
// rtl/ifetch_stage.sv - instruction fetch front end: PC, imem issue, redirect squash
// Purpose: owns the PC, reads the 1-cycle-latency imem and hands {instr, pc, pc+inc}
//          to decode over valid/ready, honouring redirects from execute.
// Ports: clk, reset (async, active-high),
//        bus (ifetch_stage_if.master): imem_en/imem_addr/imem_rdata, redirect_valid/redirect_pc,
//        if_valid/if_ready/if_instr/if_pc/if_pc_plus4.
module ifetch_stage
  import ifetch_stage_pkg::*;
  #(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [ADDR_W-1:0] PC_INC   = DEFAULT_PC_INC
) (
  input  logic           clk,
  input  logic           reset,
  ifetch_stage_if.master bus
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  logic              inflight_q;
  logic              issue;
  logic              hold_valid;
  logic              out_valid;
  logic [ADDR_W-1:0] fetch_addr;
  logic              resp_valid;
  fetch_bundle_t     resp;
  fetch_bundle_t     out_data;

  // Issue only when the response is guaranteed a slot: no held entry and no
  // stalled output. A redirect always issues because it flushes both.
  assign issue      = bus.redirect_valid | (~hold_valid & ~(out_valid & ~bus.if_ready));
  assign fetch_addr = bus.redirect_valid ? bus.redirect_pc : pc_q;

  assign bus.imem_en   = issue & ~reset;
  assign bus.imem_addr = fetch_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else if (issue) begin
      pc_q       <= fetch_addr + PC_INC;
      req_pc_q   <= fetch_addr;
      inflight_q <= 1'b1;
    end else begin
      inflight_q <= 1'b0;
    end
  end

  // A redirect discards the wrong-path read currently returning.
  assign resp_valid = inflight_q & ~bus.redirect_valid;
  assign resp       = make_bundle(bus.imem_rdata, req_pc_q, PC_INC);

  fetch_skid_buf u_skid (
    .clk        (clk),
    .reset      (reset),
    .flush      (bus.redirect_valid),
    .in_valid   (resp_valid),
    .in_data    (resp),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (bus.if_ready),
    .hold_valid (hold_valid)
  );

  assign bus.if_valid    = out_valid;
  assign bus.if_instr    = out_data.instr;
  assign bus.if_pc       = out_data.pc;
  assign bus.if_pc_plus4 = out_data.pc_plus4;

endmodule
